// File: rtl/quad_encoder_tx_pkg.sv
// Shared definitions for the quadrature transmitter: Gray phase tables,
// engine state encoding and accumulator range helpers.
package quad_encoder_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PH1,
        PH2,
        PH3,
        PH4
    } eng_state_e;

    localparam logic [1:0] DETENT = 2'b11;

    // {A,B} per phase; the last entry of each table is the detent.
    localparam logic [1:0] CW_SEQ  [0:3] = '{2'b01, 2'b00, 2'b10, 2'b11};
    localparam logic [1:0] CCW_SEQ [0:3] = '{2'b10, 2'b00, 2'b01, 2'b11};

    function automatic logic [1:0] phase_code(input logic dir_cw, input logic [1:0] idx);
        return dir_cw ? CW_SEQ[idx] : CCW_SEQ[idx];
    endfunction

    function automatic int pend_max(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    function automatic int pend_min(input int cnt_w);
        return -(1 << (cnt_w - 1));
    endfunction

endpackage

// File: rtl/quad_encoder_tx_phase_timer.sv
// Loadable down-counter that paces each Gray phase; expire_o is high while
// the count sits at zero.
module quad_phase_timer #(
    parameter int PHASE_TICKS = 50000
) (
    input  logic qzt_clk,
    input  logic reset_n,
    input  logic load_i,
    output logic expire_o
);

    localparam int            TW     = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(PHASE_TICKS - 1);
    localparam logic [TW-1:0] ONE    = TW'(1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // NOTE: combinational next-state uses blocking '=' with a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // NOTE: state registers use non-blocking '<=' and take the async reset value directly.
    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/quad_encoder_tx.sv
// Quadrature A/B transmitter: step requests feed a signed pending counter that
// a four-phase Gray engine drains one detent at a time.
module quad_encoder_tx
    import quad_encoder_tx_pkg::*;
#(
    parameter int PHASE_TICKS = 50000,
    parameter int CNT_W       = 8
) (
    input  logic             qzt_clk,
    input  logic             reset_n,
    input  logic             step_valid,
    input  logic             step_dir,
    output logic             step_ready,
    output logic             rot_A,
    output logic             rot_B,
    output logic             busy,
    output logic [CNT_W-1:0] pending
);

    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pend_max(CNT_W));
    localparam logic [CNT_W-1:0] PEND_MIN = CNT_W'(pend_min(CNT_W));
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    eng_state_e       state_q, state_d;
    logic [1:0]       ab_q, ab_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] pend_q, pend_d;

    logic pend_nz;
    logic accept;
    logic step_start;
    logic timer_load;
    logic timer_expire;

    quad_phase_timer #(
        .PHASE_TICKS(PHASE_TICKS)
    ) u_timer (
        .qzt_clk (qzt_clk),
        .reset_n (reset_n),
        .load_i  (timer_load),
        .expire_o(timer_expire)
    );

    assign pend_nz    = (pend_q != '0);
    assign step_ready = !(step_dir && (pend_q == PEND_MAX)) &&
                        !(!step_dir && (pend_q == PEND_MIN));
    assign accept     = step_valid && step_ready;

    always_comb begin
        state_d    = state_q;
        ab_d       = ab_q;
        dir_d      = dir_q;
        timer_load = 1'b0;
        step_start = 1'b0;

        unique case (state_q)
            IDLE: step_start = pend_nz;
            PH1: begin
                if (timer_expire) begin
                    ab_d       = phase_code(dir_q, 2'd1);
                    timer_load = 1'b1;
                    state_d    = PH2;
                end
            end
            PH2: begin
                if (timer_expire) begin
                    ab_d       = phase_code(dir_q, 2'd2);
                    timer_load = 1'b1;
                    state_d    = PH3;
                end
            end
            PH3: begin
                if (timer_expire) begin
                    ab_d       = phase_code(dir_q, 2'd3);
                    timer_load = 1'b1;
                    state_d    = PH4;
                end
            end
            PH4: begin
                // Detent has been held a full phase; chain straight into the next step if one waits.
                if (timer_expire) begin
                    if (pend_nz) begin
                        step_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (step_start) begin
            dir_d      = ~pend_q[CNT_W-1];
            ab_d       = phase_code(dir_d, 2'd0);
            timer_load = 1'b1;
            state_d    = PH1;
        end
    end

    // Accept and start combine in one update; saturation in step_ready keeps this from wrapping.
    always_comb begin
        pend_d = pend_q;
        if (accept) begin
            pend_d = step_dir ? (pend_d + ONE) : (pend_d - ONE);
        end
        if (step_start) begin
            pend_d = pend_q[CNT_W-1] ? (pend_d + ONE) : (pend_d - ONE);
        end
    end

    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ab_q    <= DETENT;
            dir_q   <= 1'b1;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            ab_q    <= ab_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
        end
    end

    assign rot_A   = ab_q[1];
    assign rot_B   = ab_q[0];
    assign busy    = (state_q != IDLE) || pend_nz;
    assign pending = pend_q;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Bench for quad_encoder_tx: a time-based reference model (step start edge plus
// elapsed cycles) checks two instances every cycle, plus hand-computed points.
module tb_quad_encoder_tx;

    localparam int P = 4;

    logic       qzt_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       valid8  = 1'b0;
    logic       dir8    = 1'b0;
    logic       valid3  = 1'b0;
    logic       dir3    = 1'b0;
    logic       ready8, a8, b8, busy8;
    logic [7:0] pend8;
    logic       ready3, a3, b3, busy3;
    logic [2:0] pend3;

    always #5 qzt_clk = ~qzt_clk;

    quad_encoder_tx #(.PHASE_TICKS(P), .CNT_W(8)) dut8 (
        .qzt_clk   (qzt_clk),
        .reset_n   (reset_n),
        .step_valid(valid8),
        .step_dir  (dir8),
        .step_ready(ready8),
        .rot_A     (a8),
        .rot_B     (b8),
        .busy      (busy8),
        .pending   (pend8)
    );

    quad_encoder_tx #(.PHASE_TICKS(P), .CNT_W(3)) dut3 (
        .qzt_clk   (qzt_clk),
        .reset_n   (reset_n),
        .step_valid(valid3),
        .step_dir  (dir3),
        .step_ready(ready3),
        .rot_A     (a3),
        .rot_B     (b3),
        .busy      (busy3),
        .pending   (pend3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: index 0 = CNT_W 8, index 1 = CNT_W 3.
    int         cyc = 0;
    int         m_pend [2] = '{0, 0};
    bit         m_act  [2] = '{0, 0};
    int         m_t0   [2] = '{0, 0};
    bit         m_cw   [2] = '{0, 0};
    int         m_max  [2] = '{127, 3};
    int         m_min  [2] = '{-128, -4};
    logic [1:0] cw_tab  [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [1:0] ccw_tab [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
    logic [1:0] prev_ab [2];
    bit         have_prev [2] = '{0, 0};

    function automatic bit m_ready(input int i, input logic dir);
        return !((dir && m_pend[i] == m_max[i]) || (!dir && m_pend[i] == m_min[i]));
    endfunction

    function automatic logic [1:0] m_ab(input int i);
        int idx;
        if (!m_act[i]) return 2'b11;
        idx = (cyc - m_t0[i]) / P;
        return m_cw[i] ? cw_tab[idx] : ccw_tab[idx];
    endfunction

    task automatic m_edge(input int i, input logic v, input logic d);
        int p;
        int delta;
        bit done;
        bit start;
        p     = m_pend[i];
        delta = 0;
        done  = m_act[i] && (cyc - m_t0[i] == 4 * P);
        start = (p != 0) && (!m_act[i] || done);
        if (done && !start) m_act[i] = 0;
        if (start) begin
            m_act[i] = 1;
            m_t0[i]  = cyc;
            m_cw[i]  = (p > 0);
            delta    = (p > 0) ? -1 : 1;
        end
        if (v && m_ready(i, d)) delta += d ? 1 : -1;
        m_pend[i] = p + delta;
    endtask

    always @(posedge qzt_clk) begin
        cyc = cyc + 1;
        if (reset_n) begin
            m_edge(0, valid8, dir8);
            m_edge(1, valid3, dir3);
        end
    end

    always @(negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            m_pend[i]    = 0;
            m_act[i]     = 0;
            have_prev[i] = 0;
        end
    end

    task automatic cmp(input int i, input logic [1:0] ab, input int pend,
                       input logic bsy, input logic rdy, input logic dir);
        string tag;
        tag = (i == 0) ? "w8" : "w3";
        check({tag, ".ab"}, ab, m_ab(i));
        check({tag, ".pending"}, pend, m_pend[i]);
        check({tag, ".busy"}, bsy, (m_act[i] || m_pend[i] != 0));
        check({tag, ".ready"}, rdy, m_ready(i, dir));
        if (have_prev[i]) check({tag, ".gray_1bit"}, ($countones(ab ^ prev_ab[i]) <= 1), 1);
        prev_ab[i]   = ab;
        have_prev[i] = 1;
    endtask

    always @(negedge qzt_clk) begin
        if (reset_n) begin
            cmp(0, {a8, b8}, $signed(pend8), busy8, ready8, dir8);
            cmp(1, {a3, b3}, $signed(pend3), busy3, ready3, dir3);
        end
    end

    task automatic at_edge(input int e);
        int n;
        n = e - cyc;
        repeat (n) @(posedge qzt_clk);
        #2;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy8 || busy3) && n < budget) begin
            at_edge(cyc + 1);
            n++;
        end
        check("drain.busy", {busy8, busy3}, 0);
    endtask

    initial begin
        int e0;

        #12;
        check("rst.ab", {a8, b8}, 2'b11);
        check("rst.pending", $signed(pend8), 0);
        check("rst.busy", busy8, 0);
        #10;
        reset_n = 1'b1;
        #1;
        check("rst.ready_after", ready8, 1);

        // Single CW pulse
        valid8 = 1'b1; dir8 = 1'b1; e0 = cyc + 1;
        at_edge(e0);      valid8 = 1'b0;
        check("cw.pend@0", $signed(pend8), 1);
        at_edge(e0 + 1);  check("cw.ab@1", {a8, b8}, 2'b01); check("cw.pend@1", $signed(pend8), 0);
        at_edge(e0 + 5);  check("cw.ab@5", {a8, b8}, 2'b00);
        at_edge(e0 + 9);  check("cw.ab@9", {a8, b8}, 2'b10);
        at_edge(e0 + 13); check("cw.ab@13", {a8, b8}, 2'b11);
        at_edge(e0 + 16); check("cw.busy@16", busy8, 1);
        at_edge(e0 + 17); check("cw.busy@17", busy8, 0);

        // Single CCW pulse
        valid8 = 1'b1; dir8 = 1'b0; e0 = cyc + 1;
        at_edge(e0);      valid8 = 1'b0;
        at_edge(e0 + 1);  check("ccw.ab@1", {a8, b8}, 2'b10);
        at_edge(e0 + 5);  check("ccw.ab@5", {a8, b8}, 2'b00);
        at_edge(e0 + 9);  check("ccw.ab@9", {a8, b8}, 2'b01);
        at_edge(e0 + 13); check("ccw.ab@13", {a8, b8}, 2'b11);
        at_edge(e0 + 17); check("ccw.busy@17", busy8, 0);

        // Three CW pulses back to back
        valid8 = 1'b1; dir8 = 1'b1; e0 = cyc + 1;
        at_edge(e0 + 2);  valid8 = 1'b0;
        check("cw3.pend_peak", $signed(pend8), 2);
        at_edge(e0 + 17); check("cw3.ab@17", {a8, b8}, 2'b01);
        at_edge(e0 + 48); check("cw3.busy@48", busy8, 1);
        at_edge(e0 + 49); check("cw3.busy@49", busy8, 0);

        // CW, CW, then cancelling CCW
        valid8 = 1'b1; dir8 = 1'b1; e0 = cyc + 1;
        at_edge(e0 + 1);  check("cancel.pend@1", $signed(pend8), 1); dir8 = 1'b0;
        at_edge(e0 + 2);  valid8 = 1'b0; check("cancel.pend@2", $signed(pend8), 0);
        at_edge(e0 + 5);  check("cancel.ab@5", {a8, b8}, 2'b00);
        at_edge(e0 + 17); check("cancel.busy@17", busy8, 0);

        // Saturation on the 3-bit instance
        valid3 = 1'b1; dir3 = 1'b1; e0 = cyc + 1;
        at_edge(e0 + 3);  check("sat.pend@3", $signed(pend3), 3); check("sat.ready@3", ready3, 0);
        at_edge(e0 + 17); check("sat.ready_after_start", ready3, 1);
        at_edge(e0 + 20); check("sat.pend@20", $signed(pend3), 3); check("sat.ready@20", ready3, 0);
        dir3 = 1'b0;
        #1;               check("sat.ccw_ready", ready3, 1);
        at_edge(e0 + 21); check("sat.ccw_taken", $signed(pend3), 2);
        valid3 = 1'b0;
        wait_idle(2000);

        // Reset during PH2
        valid8 = 1'b1; dir8 = 1'b1; e0 = cyc + 1;
        at_edge(e0);      valid8 = 1'b0;
        at_edge(e0 + 6);  check("rstmid.ab_ph2", {a8, b8}, 2'b00);
        reset_n = 1'b0;
        #1;
        check("rstmid.ab", {a8, b8}, 2'b11);
        check("rstmid.pending", $signed(pend8), 0);
        check("rstmid.busy", busy8, 0);
        at_edge(cyc + 1);
        reset_n = 1'b1;
        at_edge(cyc + 20);
        check("rstmid.ab_after", {a8, b8}, 2'b11);
        check("rstmid.busy_after", busy8, 0);

        // Randomized traffic on both instances
        repeat (400) begin
            valid8 = 1'($urandom_range(0, 1));
            dir8   = 1'($urandom_range(0, 1));
            valid3 = 1'($urandom_range(0, 1));
            dir3   = ($urandom_range(0, 3) != 0);
            at_edge(cyc + 1);
        end
        valid8 = 1'b0;
        valid3 = 1'b0;
        wait_idle(6000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
